// File: rtl/mem_byte_lanes_rw.sv
// Byte-lane data memory for the MEM stage: RISC-V load/store sizing, lane
// alignment, sign/zero extension, fault flags and a saturating error counter.
module mem_byte_lanes_rw #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter     INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_misaligned,
  output logic                  rsp_illegal,
  output logic [15:0]           err_count
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;
  localparam int OFF_W     = $clog2(NUM_BYTES);
  localparam int IDX_W     = ADDR_WIDTH - OFF_W;
  localparam int DEPTH     = 1 << IDX_W;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [IDX_W-1:0]      idx;
  logic [OFF_W-1:0]      offset;
  logic [3:0]            size_bytes;
  logic                  illegal;
  logic                  misaligned;
  logic [NUM_BYTES-1:0]  lane_mask;
  logic [DATA_WIDTH-1:0] wdata_lanes;
  logic [DATA_WIDTH-1:0] cur_word;
  logic [DATA_WIDTH-1:0] merged_word;
  logic                  do_write;

  assign idx    = req_addr[ADDR_WIDTH-1:OFF_W];
  assign offset = req_addr[OFF_W-1:0];

  // Illegal encodings win over alignment, so a bad funct3 never reports misaligned.
  always_comb begin
    case (req_funct3[1:0])
      2'b00:   size_bytes = 4'd1;
      2'b01:   size_bytes = 4'd2;
      2'b10:   size_bytes = 4'd4;
      default: size_bytes = 4'd8;
    endcase
    illegal = (req_funct3 == 3'b111)
           || ((DATA_WIDTH == 32) && ((req_funct3 == 3'b011) || (req_funct3 == 3'b110)))
           || (req_we && req_funct3[2]);
    misaligned  = !illegal && ((4'(offset) & (size_bytes - 4'd1)) != 4'd0);
    lane_mask   = NUM_BYTES'((32'd1 << size_bytes) - 32'd1) << offset;
    wdata_lanes = req_wdata << {offset, 3'b000};
    do_write    = req_valid && !rst && req_we && !illegal && !misaligned;
    cur_word    = mem[idx];
    merged_word = cur_word;
    for (int b = 0; b < NUM_BYTES; b++) begin
      if (do_write && lane_mask[b]) merged_word[8*b +: 8] = wdata_lanes[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) mem[idx] <= merged_word;
  end

  logic [DATA_WIDTH-1:0] rd_word;
  logic [OFF_W-1:0]      rd_offset;
  logic [2:0]            rd_funct3;
  logic                  rd_load;

  // The captured word is the post-merge value, giving write-first store responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid      <= 1'b0;
      rsp_misaligned <= 1'b0;
      rsp_illegal    <= 1'b0;
      err_count      <= 16'd0;
      rd_word        <= '0;
      rd_offset      <= '0;
      rd_funct3      <= 3'b000;
      rd_load        <= 1'b0;
    end else begin
      rsp_valid <= req_valid;
      if (req_valid) begin
        rd_word        <= merged_word;
        rd_offset      <= offset;
        rd_funct3      <= req_funct3;
        rd_load        <= !req_we;
        rsp_misaligned <= misaligned;
        rsp_illegal    <= illegal;
        if ((misaligned || illegal) && (err_count != 16'hFFFF))
          err_count <= err_count + 16'd1;
      end
    end
  end

  logic [DATA_WIDTH-1:0] rd_shifted;
  logic [DATA_WIDTH-1:0] load_ext;

  always_comb begin
    rd_shifted = rd_word >> {rd_offset, 3'b000};
    case (rd_funct3)
      3'b000:  load_ext = DATA_WIDTH'($signed(rd_shifted[7:0]));
      3'b001:  load_ext = DATA_WIDTH'($signed(rd_shifted[15:0]));
      3'b010:  load_ext = DATA_WIDTH'($signed(rd_shifted[31:0]));
      3'b100:  load_ext = DATA_WIDTH'(rd_shifted[7:0]);
      3'b101:  load_ext = DATA_WIDTH'(rd_shifted[15:0]);
      3'b110:  load_ext = DATA_WIDTH'(rd_shifted[31:0]);
      default: load_ext = rd_shifted;
    endcase
    if (!rd_load)
      rsp_rdata = rd_word;
    else if (rsp_misaligned || rsp_illegal)
      rsp_rdata = '0;
    else
      rsp_rdata = load_ext;
  end

endmodule

// File: tb/tb_mem_byte_lanes_rw.sv
// Scoreboard bench for mem_byte_lanes_rw: a 32-bit and a 64-bit instance share
// one clock; stimulus pushes expected responses, per-instance monitors check them.
module tb_mem_byte_lanes_rw;

  typedef struct {
    logic [63:0] rdata;
    logic        mis;
    logic        ill;
    logic [15:0] err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        v32 = 1'b0, we32 = 1'b0;
  logic [2:0]  f3_32 = 3'b000;
  logic [11:0] addr32 = '0;
  logic [31:0] wd32 = '0;
  logic        rv32, mis32, ill32;
  logic [31:0] rd32;
  logic [15:0] err32;

  logic        v64 = 1'b0, we64 = 1'b0;
  logic [2:0]  f3_64 = 3'b000;
  logic [11:0] addr64 = '0;
  logic [63:0] wd64 = '0;
  logic        rv64, mis64, ill64;
  logic [63:0] rd64;
  logic [15:0] err64;

  exp_t q32[$];
  exp_t q64[$];
  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  mem_byte_lanes_rw #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) dut32 (
    .clk(clk), .rst(rst), .req_valid(v32), .req_we(we32), .req_funct3(f3_32),
    .req_addr(addr32), .req_wdata(wd32), .rsp_valid(rv32), .rsp_rdata(rd32),
    .rsp_misaligned(mis32), .rsp_illegal(ill32), .err_count(err32));

  mem_byte_lanes_rw #(.DATA_WIDTH(64), .ADDR_WIDTH(12)) dut64 (
    .clk(clk), .rst(rst), .req_valid(v64), .req_we(we64), .req_funct3(f3_64),
    .req_addr(addr64), .req_wdata(wd64), .rsp_valid(rv64), .rsp_rdata(rd64),
    .rsp_misaligned(mis64), .rsp_illegal(ill64), .err_count(err64));

  task automatic checkOutput(input string name, input logic [81:0] act, input logic [81:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic applyStimulus(input bit wide, input logic we, input logic [2:0] f3,
                               input logic [11:0] addr, input logic [63:0] wdata,
                               input logic [63:0] exp_rd, input logic exp_mis,
                               input logic exp_ill, input logic [15:0] exp_err);
    exp_t e;
    @(negedge clk);
    e.rdata = exp_rd;
    e.mis   = exp_mis;
    e.ill   = exp_ill;
    e.err   = exp_err;
    if (wide) begin
      q64.push_back(e);
      v64 = 1'b1; we64 = we; f3_64 = f3; addr64 = addr; wd64 = wdata;
      v32 = 1'b0;
    end else begin
      q32.push_back(e);
      v32 = 1'b1; we32 = we; f3_32 = f3; addr32 = addr; wd32 = wdata[31:0];
      v64 = 1'b0;
    end
  endtask

  task automatic idle();
    @(negedge clk);
    v32 = 1'b0;
    v64 = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rv32) begin
      if (q32.size() == 0) begin
        checkOutput("dut32 unexpected response", {50'd0, rd32}, 82'd0);
      end else begin
        exp_t e;
        e = q32.pop_front();
        checkOutput("dut32 response", {32'd0, rd32, mis32, ill32, err32},
                    {e.rdata, e.mis, e.ill, e.err});
      end
    end
  end

  always @(negedge clk) begin
    if (rv64) begin
      if (q64.size() == 0) begin
        checkOutput("dut64 unexpected response", {18'd0, rd64}, 82'd0);
      end else begin
        exp_t e;
        e = q64.pop_front();
        checkOutput("dut64 response", {rd64, mis64, ill64, err64},
                    {e.rdata, e.mis, e.ill, e.err});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("reset rsp_valid32", 82'(rv32), 82'd0);
    checkOutput("reset rdata32", 82'(rd32), 82'd0);
    checkOutput("reset flags/err32", 82'({mis32, ill32, err32}), 82'd0);
    checkOutput("reset state64", 82'({rv64, mis64, ill64, err64}), 82'd0);
    rst = 1'b0;

    // 32-bit word, byte and half accesses
    applyStimulus(0, 1, 3'b010, 12'h010, 64'h8000_00F1, 64'h8000_00F1, 0, 0, 16'd0);
    applyStimulus(0, 1, 3'b000, 12'h012, 64'hAB,        64'h80AB_00F1, 0, 0, 16'd0);
    applyStimulus(0, 0, 3'b000, 12'h012, 64'h0,         64'hFFFF_FFAB, 0, 0, 16'd0);
    applyStimulus(0, 0, 3'b100, 12'h012, 64'h0,         64'h0000_00AB, 0, 0, 16'd0);
    applyStimulus(0, 0, 3'b010, 12'h010, 64'h0,         64'h80AB_00F1, 0, 0, 16'd0);
    applyStimulus(0, 1, 3'b001, 12'h011, 64'h1234,      64'h80AB_00F1, 1, 0, 16'd1);
    applyStimulus(0, 0, 3'b010, 12'h010, 64'h0,         64'h80AB_00F1, 0, 0, 16'd1);
    applyStimulus(0, 0, 3'b010, 12'h013, 64'h0,         64'h0,         1, 0, 16'd2);
    applyStimulus(0, 0, 3'b001, 12'h012, 64'h0,         64'hFFFF_80AB, 0, 0, 16'd2);
    applyStimulus(0, 0, 3'b101, 12'h012, 64'h0,         64'h0000_80AB, 0, 0, 16'd2);
    applyStimulus(0, 1, 3'b001, 12'h010, 64'hBEEF,      64'h80AB_BEEF, 0, 0, 16'd2);
    applyStimulus(0, 0, 3'b000, 12'h013, 64'h0,         64'hFFFF_FF80, 0, 0, 16'd2);
    applyStimulus(0, 0, 3'b000, 12'h010, 64'h0,         64'hFFFF_FFEF, 0, 0, 16'd2);
    applyStimulus(0, 0, 3'b100, 12'h011, 64'h0,         64'h0000_00BE, 0, 0, 16'd2);

    // Illegal encodings on the 32-bit instance
    applyStimulus(0, 0, 3'b011, 12'h010, 64'h0,         64'h0,         0, 1, 16'd3);
    applyStimulus(0, 1, 3'b100, 12'h010, 64'h55,        64'h80AB_BEEF, 0, 1, 16'd4);
    applyStimulus(0, 0, 3'b010, 12'h010, 64'h0,         64'h80AB_BEEF, 0, 0, 16'd4);
    applyStimulus(0, 0, 3'b111, 12'h011, 64'h0,         64'h0,         0, 1, 16'd5);
    applyStimulus(0, 1, 3'b110, 12'h010, 64'h77,        64'h80AB_BEEF, 0, 1, 16'd6);

    // A store issued during reset must be dropped
    applyStimulus(0, 1, 3'b010, 12'h020, 64'hCAFE_F00D, 64'hCAFE_F00D, 0, 0, 16'd6);
    @(negedge clk);
    rst = 1'b1;
    v32 = 1'b1; we32 = 1'b1; f3_32 = 3'b010; addr32 = 12'h020; wd32 = 32'h1234_5678;
    @(negedge clk);
    checkOutput("rsp_valid32 low in reset", 82'(rv32), 82'd0);
    checkOutput("err32 cleared by reset", 82'(err32), 82'd0);
    rst = 1'b0;
    v32 = 1'b0;
    applyStimulus(0, 0, 3'b010, 12'h020, 64'h0,         64'hCAFE_F00D, 0, 0, 16'd0);
    idle();

    // 64-bit doubleword and sub-word accesses
    applyStimulus(1, 1, 3'b011, 12'h008, 64'h1122_3344_5566_7788, 64'h1122_3344_5566_7788, 0, 0, 16'd0);
    applyStimulus(1, 0, 3'b110, 12'h00C, 64'h0, 64'h0000_0000_1122_3344, 0, 0, 16'd0);
    applyStimulus(1, 0, 3'b010, 12'h00C, 64'h0, 64'h0000_0000_1122_3344, 0, 0, 16'd0);
    applyStimulus(1, 0, 3'b000, 12'h00F, 64'h0, 64'h0000_0000_0000_0011, 0, 0, 16'd0);
    applyStimulus(1, 0, 3'b001, 12'h00A, 64'h0, 64'h0000_0000_0000_5566, 0, 0, 16'd0);
    applyStimulus(1, 0, 3'b010, 12'h008, 64'h0, 64'h0000_0000_5566_7788, 0, 0, 16'd0);
    applyStimulus(1, 1, 3'b010, 12'h00C, 64'h8000_0001, 64'h8000_0001_5566_7788, 0, 0, 16'd0);
    applyStimulus(1, 0, 3'b010, 12'h00C, 64'h0, 64'hFFFF_FFFF_8000_0001, 0, 0, 16'd0);
    applyStimulus(1, 0, 3'b011, 12'h008, 64'h0, 64'h8000_0001_5566_7788, 0, 0, 16'd0);

    // Drive the error counter past saturation
    for (int i = 1; i <= 65537; i++) begin
      applyStimulus(1, 0, 3'b001, 12'h009, 64'h0, 64'h0, 1, 0,
                    (i >= 65535) ? 16'hFFFF : 16'(i));
    end
    idle();
    repeat (3) @(negedge clk);
    checkOutput("err64 saturated", 82'(err64), 82'hFFFF);
    checkOutput("q32 drained", 82'(q32.size()), 82'd0);
    checkOutput("q64 drained", 82'(q64.size()), 82'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
